// File: rtl/hazard_ctrl.sv
// Pipeline hazard, redirect and trap-sequencing controller for a 5-stage core.
// Optional timer interrupt source is compiled in with `define HAZARD_TIMER_INT_EN.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1addr,
    input  logic [4:0] id_rs2addr,
    input  logic [4:0] exe_rs1addr,
    input  logic [4:0] exe_rs2addr,
    input  logic [4:0] exe_rdaddr,
    input  logic       exe_memread,
    input  logic       exe_branch_taken,
    input  logic       exe_jal,
    input  logic       exe_jalr,
    input  logic       exe_wfi,
    input  logic       exe_mret,
    input  logic [4:0] mem_rdaddr,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rdaddr,
    input  logic       wb_regwrite,
    input  logic       im_stall,
    input  logic       dm_stall,
    input  logic       interrupt,
    input  logic       timeout,
    input  logic       mie,
    output logic [1:0] fwd_rs1src,
    output logic [1:0] fwd_rs2src,
    output logic [1:0] pc_sel,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idexe_flush,
    output logic       pipe_hold,
    output logic       trap_take,
    output logic       trap_ret,
    output logic       wfi_sleep
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        TRAP1 = 3'd1,
        TRAP2 = 3'd2,
        RET1  = 3'd3,
        RET2  = 3'd4,
        SLEEP = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   lu_q, lu_d;
    logic   tmr_src;
    logic   bus_wait;
    logic   trap_pend;
    logic   wake;
    logic   load_use;

`ifdef HAZARD_TIMER_INT_EN
    assign tmr_src = timeout;
`else
    logic unused_timeout;
    assign unused_timeout = timeout;
    assign tmr_src        = 1'b0;
`endif

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) return 2'b01;
        if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b10;
        return 2'b00;
    endfunction

    assign fwd_rs1src = fwd_sel(exe_rs1addr, mem_rdaddr, mem_regwrite, wb_rdaddr, wb_regwrite);
    assign fwd_rs2src = fwd_sel(exe_rs2addr, mem_rdaddr, mem_regwrite, wb_rdaddr, wb_regwrite);

    assign bus_wait  = im_stall | dm_stall;
    assign wake      = interrupt | tmr_src;
    assign trap_pend = mie & wake;
    assign load_use  = exe_memread && (exe_rdaddr != 5'd0) &&
                       ((exe_rdaddr == id_rs1addr) || (exe_rdaddr == id_rs2addr));

    // Outputs decode the same-cycle EXE event, so they are combinational on
    // state_q; lu_q masks the load-use check for the cycle after the bubble.
    always_comb begin
        state_d     = state_q;
        lu_d        = 1'b0;
        pc_sel      = 2'b00;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        pipe_hold   = 1'b0;
        trap_take   = 1'b0;
        trap_ret    = 1'b0;
        wfi_sleep   = 1'b0;

        if (bus_wait) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            lu_d       = lu_q;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (trap_pend) begin
                        trap_take   = 1'b1;
                        pc_sel      = 2'b11;
                        ifid_flush  = 1'b1;
                        idexe_flush = 1'b1;
                        state_d     = TRAP1;
                    end else if (exe_mret) begin
                        trap_ret    = 1'b1;
                        pc_sel      = 2'b11;
                        ifid_flush  = 1'b1;
                        idexe_flush = 1'b1;
                        state_d     = RET1;
                    end else if (exe_wfi) begin
                        wfi_sleep   = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idexe_flush = 1'b1;
                        state_d     = SLEEP;
                    end else if (exe_branch_taken || exe_jal || exe_jalr) begin
                        pc_sel      = (exe_branch_taken || exe_jal) ? 2'b01 : 2'b10;
                        ifid_flush  = 1'b1;
                        idexe_flush = 1'b1;
                    end else if (load_use && !lu_q) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idexe_flush = 1'b1;
                        lu_d        = 1'b1;
                    end
                end
                TRAP1, RET1: begin
                    ifid_flush  = 1'b1;
                    idexe_flush = 1'b1;
                    state_d     = (state_q == TRAP1) ? TRAP2 : RET2;
                end
                TRAP2, RET2: begin
                    ifid_flush = 1'b1;
                    state_d    = RUN;
                end
                SLEEP: begin
                    if (trap_pend) begin
                        trap_take   = 1'b1;
                        pc_sel      = 2'b11;
                        ifid_flush  = 1'b1;
                        idexe_flush = 1'b1;
                        state_d     = TRAP1;
                    end else if (wake) begin
                        state_d = RUN;
                    end else begin
                        wfi_sleep   = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idexe_flush = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        if (rst) begin
            pc_sel      = 2'b00;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            pipe_hold   = 1'b0;
            trap_take   = 1'b0;
            trap_ret    = 1'b0;
            wfi_sleep   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            lu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lu_q    <= lu_d;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-002 SHALL have ID-stage source addresses: id_rs1addr in 5, id_rs2addr in 5.
REQ-003 SHALL have EXE-stage inputs: exe_rs1addr in 5, exe_rs2addr in 5, exe_rdaddr in 5, exe_memread in 1, exe_branch_taken in 1, exe_jal in 1, exe_jalr in 1, exe_wfi in 1, exe_mret in 1.
REQ-004 SHALL have later-stage inputs: mem_rdaddr in 5, mem_regwrite in 1, wb_rdaddr in 5, wb_regwrite in 1.
REQ-005 SHALL have bus/trap inputs: im_stall in 1 (fetch wait), dm_stall in 1 (data wait), interrupt in 1 (external), timeout in 1 (timer), mie in 1 (global interrupt enable).
REQ-006 SHALL have outputs: fwd_rs1src out 2, fwd_rs2src out 2 (00 regfile, 01 MEM, 10 WB); pc_sel out 2 (00 PC+4, 01 PC+imm, 10 jalr, 11 trap/return vector).
REQ-007 SHALL have outputs: pc_write out 1, ifid_write out 1, ifid_flush out 1, idexe_flush out 1, pipe_hold out 1 (freeze all stage registers), trap_take out 1, trap_ret out 1, wfi_sleep out 1.

Function
REQ-008 Forwarding SHALL be combinational: fwd_rsNsrc=01 if mem_regwrite and mem_rdaddr!=0 and mem_rdaddr==exe_rsNaddr; else 10 if same test on WB; else 00; MEM wins over WB.
REQ-009 FSM states SHALL be RUN, TRAP1, TRAP2, RET1, RET2, SLEEP; RUN after reset.
REQ-010 Event priority in RUN, highest first: bus wait, trap entry, mret, wfi, branch/jump, load-use.
REQ-011 Bus wait (im_stall|dm_stall) SHALL assert pipe_hold, deassert pc_write/ifid_write, assert no flush, and hold state; other events are evaluated only once wait clears.
REQ-012 Trap pending = mie & (interrupt | timeout-term per REQ-027); in RUN it SHALL assert trap_take for one cycle, pc_sel=11, ifid_flush and idexe_flush, and go TRAP1.
REQ-013 TRAP1 SHALL keep both flushes asserted, pc_write=1, pc_sel=00; next TRAP2. TRAP2 SHALL assert ifid_flush only, then return to RUN (2-cycle drain after redirect).
REQ-014 exe_mret in RUN SHALL assert trap_ret one cycle, pc_sel=11, both flushes; go RET1 then RET2 with the same flush pattern as TRAP1/TRAP2; interrupts are ignored in RET1/RET2.
REQ-015 exe_wfi in RUN with no trap pending SHALL go SLEEP: wfi_sleep=1, pc_write=0, ifid_write=0, idexe_flush=1 each cycle.
REQ-016 SLEEP SHALL exit on trap pending (same outputs as REQ-012, to TRAP1); with mie=0 it SHALL exit on raw interrupt to RUN, resuming at PC+4 without trap.
REQ-017 Branch/jump in RUN: exe_branch_taken or exe_jal -> pc_sel=01; exe_jalr -> pc_sel=10; both flushes asserted one cycle; state stays RUN.
REQ-018 Load-use in RUN: exe_memread & exe_rdaddr!=0 & (exe_rdaddr==id_rs1addr | exe_rdaddr==id_rs2addr) SHALL give pc_write=0, ifid_write=0, idexe_flush=1 for exactly one cycle.
REQ-019 Branch and load-use same cycle: branch SHALL win (flush, no stall).
REQ-020 Default RUN outputs: pc_sel=00, pc_write=1, ifid_write=1, flushes/hold/trap_take/trap_ret/wfi_sleep=0.
REQ-021 Bus wait during TRAPn/RETn SHALL freeze the state (no advance) with pipe_hold=1 and flushes suppressed.
REQ-022 trap_take and trap_ret SHALL never be asserted together, each at most one cycle per event.

Reset
REQ-023 rst SHALL force state RUN immediately, independent of clk, including mid-TRAP/RET/SLEEP.
REQ-024 During rst: pc_write=0, ifid_write=0, ifid_flush=1, idexe_flush=1, pipe_hold=0, pc_sel=00, trap_take=trap_ret=wfi_sleep=0; forwarding remains combinational.
REQ-025 First clock edge after rst release SHALL evaluate RUN rules of REQ-010.

Configuration
REQ-026 Macro HAZARD_TIMER_INT_EN SHALL select the timer-interrupt feature.
REQ-027 Defined: timeout SHALL be a trap source ORed with interrupt. Undefined: timeout SHALL be ignored entirely (no trap, no SLEEP wake).

Verification
REQ-028 exe_memread=1, exe_rdaddr=5, id_rs2addr=5 -> one cycle pc_write=0, idexe_flush=1, then normal.
REQ-029 mem_regwrite=1, mem_rdaddr=3, wb_regwrite=1, wb_rdaddr=3, exe_rs1addr=3 -> fwd_rs1src=01; same with rdaddr=0 -> 00.
REQ-030 mie=1, interrupt pulse in RUN -> trap_take 1 cycle, pc_sel=11, states TRAP1,TRAP2,RUN; with dm_stall=1 in TRAP1 for 3 cycles -> TRAP1 held 3 extra cycles.
REQ-031 exe_wfi=1, then interrupt after 10 cycles with mie=1 -> wfi_sleep=1 for 10 cycles, then trap_take; with mie=0 -> back to RUN, no trap_take.
REQ-032 exe_branch_taken=1 with simultaneous load-use hazard -> pc_sel=01, both flushes, pc_write=1.
REQ-033 rst asserted mid-RET1 -> outputs per REQ-024 without clk edge; macro undefined, timeout=1, mie=1 -> no trap_take.
